// File: rtl/wm_spin_pkg.sv
// Shared definitions for the spin motor ramp logic.
//   RPM_W        width of every RPM quantity
//   MAX_RPM      largest target the spin-speed selector will legally produce
//   spin_state_e FSM state encoding, also exported on spin_state
package wm_spin_pkg;

    localparam int unsigned RPM_W   = 11;
    localparam int unsigned MAX_RPM = 1600;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRampUp   = 2'd1,
        StHold     = 2'd2,
        StRampDown = 2'd3
    } spin_state_e;

endpackage

// File: rtl/spin_step_timer.sv
// Clearable divide-by-TICK_DIV tick generator.
//   clk     system clock
//   reset   asynchronous, active-low reset
//   clear   synchronously returns the divider to 0 (wins over enable)
//   enable  advance the divider this cycle
//   tick    high for the one cycle in which the divider sits at TICK_DIV-1 while enabled
module spin_step_timer #(
    parameter int unsigned TICK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign tick = enable && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spin_motor_ramp_controller.sv
// Spin-cycle motor speed ramp: latches a target RPM on start, ramps up in fixed steps,
// holds for HOLD_CYCLES cycles, ramps down to zero and pulses completion.
//   clk, reset            system clock, asynchronous active-low reset
//   spin_start            start request, honoured only in IDLE with the door locked
//   spin_abort            level, forces ramp-down from RAMP_UP or HOLD
//   door_locked           level, low forces ramp-down / blocks a start
//   selected_spin_speed   target RPM, sampled on an accepted start
//   motor_rpm             commanded motor RPM
//   spin_active           high outside IDLE
//   spin_done             one-cycle pulse in the first IDLE cycle after a spin
//   spin_aborted          set on forced ramp-down, cleared by the next accepted start
//   spin_state            current state encoding
module spin_motor_ramp_controller
    import wm_spin_pkg::*;
#(
    parameter int unsigned STEP_RPM    = 100,
    parameter int unsigned TICK_DIV    = 5,
    parameter int unsigned HOLD_CYCLES = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spin_start,
    input  logic             spin_abort,
    input  logic             door_locked,
    input  logic [RPM_W-1:0] selected_spin_speed,
    output logic [RPM_W-1:0] motor_rpm,
    output logic             spin_active,
    output logic             spin_done,
    output logic             spin_aborted,
    output logic [1:0]       spin_state
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [RPM_W-1:0] Step     = RPM_W'(STEP_RPM);
    localparam logic [RPM_W:0]   StepExt  = (RPM_W + 1)'(STEP_RPM);

    spin_state_e      state_q, state_d;
    logic [RPM_W-1:0] rpm_q, rpm_d;
    logic [RPM_W-1:0] target_q, target_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             aborted_q, aborted_d;
    logic             done_q, done_d;

    logic             tick;
    logic             forced;
    logic [RPM_W:0]   rpm_sum;

    // One extra bit so rpm + step cannot wrap before the target clamp.
    assign rpm_sum = {1'b0, rpm_q} + StepExt;
    assign forced  = spin_abort || !door_locked;

    // Divider restarts on every state change so each ramp phase begins a full step away.
    spin_step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_d != state_q),
        .enable ((state_q == StRampUp) || (state_q == StRampDown)),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        rpm_d     = rpm_q;
        target_d  = target_q;
        hold_d    = hold_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (spin_start && door_locked) begin
                    target_d  = selected_spin_speed;
                    aborted_d = 1'b0;
                    state_d   = (selected_spin_speed == '0) ? StRampDown : StRampUp;
                end
            end
            StRampUp: begin
                if (forced) begin
                    state_d   = StRampDown;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    if (rpm_sum >= {1'b0, target_q}) begin
                        rpm_d   = target_q;
                        hold_d  = '0;
                        state_d = StHold;
                    end else begin
                        rpm_d = rpm_sum[RPM_W-1:0];
                    end
                end
            end
            StHold: begin
                if (forced) begin
                    state_d   = StRampDown;
                    aborted_d = 1'b1;
                end else if (hold_q == HoldLast) begin
                    state_d = StRampDown;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRampDown: begin
                // Entering at 0 RPM (zero target or very early abort) finishes at once.
                if (rpm_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (tick) begin
                    if (rpm_q <= Step) begin
                        rpm_d   = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        rpm_d = rpm_q - Step;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rpm_q     <= '0;
            target_q  <= '0;
            hold_q    <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpm_q     <= rpm_d;
            target_q  <= target_d;
            hold_q    <= hold_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    assign motor_rpm    = rpm_q;
    assign spin_active  = (state_q != StIdle);
    assign spin_done    = done_q;
    assign spin_aborted = aborted_q;
    assign spin_state   = state_q;

endmodule

// File: tb/tb_spin_motor_ramp_controller.sv
module tb_spin_motor_ramp_controller;

    localparam int STEP = 100;
    localparam int DIV  = 5;
    localparam int HOLD = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        spin_start;
    logic        spin_abort;
    logic        door_locked;
    logic [10:0] selected_spin_speed;
    logic [10:0] motor_rpm;
    logic        spin_active;
    logic        spin_done;
    logic        spin_aborted;
    logic [1:0]  spin_state;

    int n_checks = 0;
    int n_fail   = 0;

    spin_motor_ramp_controller #(
        .STEP_RPM    (STEP),
        .TICK_DIV    (DIV),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .spin_start          (spin_start),
        .spin_abort          (spin_abort),
        .door_locked         (door_locked),
        .selected_spin_speed (selected_spin_speed),
        .motor_rpm           (motor_rpm),
        .spin_active         (spin_active),
        .spin_done           (spin_done),
        .spin_aborted        (spin_aborted),
        .spin_state          (spin_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs d edges after the accept edge (d=0), for target t and a forced stop
    // applied during cycle da (-1: none). Built from the phase durations directly:
    // ramp-up of ceil(t/STEP) steps, HOLD cycles of hold, ramp-down from the frozen speed.
    function automatic void model(input int t, input int da, input int d,
                                  output int st, output int rpm, output int done,
                                  output int ab, output int di);
        int n, dr, r0, dur, up;
        bit forced;
        n      = (t + STEP - 1) / STEP;
        forced = 1'b0;
        if (t == 0) begin
            dr = 0;
            r0 = 0;
        end else begin
            dr = DIV * n + HOLD;
            r0 = t;
        end
        if (da >= 0 && da < dr) begin
            up = (da / DIV) * STEP;
            if (up > t) up = t;
            r0     = up;
            dr     = da + 1;
            forced = 1'b1;
        end
        dur  = (r0 == 0) ? 1 : DIV * ((r0 + STEP - 1) / STEP);
        di   = dr + dur;
        done = (d == di) ? 1 : 0;
        ab   = (forced && d >= dr) ? 1 : 0;
        if (d < dr) begin
            if (d < DIV * n) begin
                st  = 1;
                rpm = (d / DIV) * STEP;
                if (rpm > t) rpm = t;
            end else begin
                st  = 2;
                rpm = t;
            end
        end else if (d < di) begin
            st  = 3;
            rpm = r0 - ((d - dr) / DIV) * STEP;
            if (rpm < 0) rpm = 0;
        end else begin
            st  = 0;
            rpm = 0;
        end
    endfunction

    // Entered and left at 1 time unit after a rising edge. Inputs that must be ignored
    // (start, speed, and abort/door during ramp-down) are randomized.
    task automatic run_spin(input int t, input int da, input bit use_door);
        int st, rpm, done, ab, di;
        int d;
        selected_spin_speed = 11'(t);
        spin_start  = 1'b1;
        door_locked = 1'b1;
        spin_abort  = 1'($urandom_range(0, 1));
        model(t, da, 0, st, rpm, done, ab, di);
        d = 0;
        while (d <= di + 1) begin
            @(posedge clk);
            #1;
            model(t, da, d, st, rpm, done, ab, di);
            check($sformatf("state t=%0d d=%0d", t, d), 32'(spin_state), 32'(st));
            check($sformatf("rpm t=%0d d=%0d", t, d), 32'(motor_rpm), 32'(rpm));
            check($sformatf("done t=%0d d=%0d", t, d), 32'(spin_done), 32'(done));
            check($sformatf("active t=%0d d=%0d", t, d), 32'(spin_active), (st != 0) ? 1 : 0);
            check($sformatf("aborted t=%0d d=%0d", t, d), 32'(spin_aborted), 32'(ab));
            selected_spin_speed = 11'($urandom_range(0, 2047));
            spin_start = (d < di) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (d == da) begin
                spin_abort  = !use_door;
                door_locked = !use_door;
            end else if (st == 3 && d < di) begin
                spin_abort  = 1'($urandom_range(0, 1));
                door_locked = 1'($urandom_range(0, 1));
            end else begin
                spin_abort  = 1'b0;
                door_locked = 1'b1;
            end
            d++;
        end
    endtask

    initial begin
        int t, mode, da, n;
        reset               = 1'b0;
        spin_start          = 1'b0;
        spin_abort          = 1'b0;
        door_locked         = 1'b1;
        selected_spin_speed = '0;
        #12;
        check("reset rpm", 32'(motor_rpm), 0);
        check("reset state", 32'(spin_state), 0);
        check("reset active", 32'(spin_active), 0);
        check("reset done", 32'(spin_done), 0);
        check("reset aborted", 32'(spin_aborted), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Door open blocks a start.
        selected_spin_speed = 11'd700;
        spin_start  = 1'b1;
        door_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("door-open state", 32'(spin_state), 0);
            check("door-open rpm", 32'(motor_rpm), 0);
        end
        spin_start  = 1'b0;
        door_locked = 1'b1;

        run_spin(1200, -1, 1'b0);
        run_spin(850, -1, 1'b0);
        run_spin(1200, 20, 1'b0);   // abort at 400 RPM
        run_spin(1200, 65, 1'b1);   // door dropped during hold
        run_spin(0, -1, 1'b0);

        // Reset clears a set aborted flag while idle.
        #2 reset = 1'b0;
        #1 check("idle reset aborted", 32'(spin_aborted), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of HOLD.
        selected_spin_speed = 11'd1200;
        spin_start  = 1'b1;
        door_locked = 1'b1;
        spin_abort  = 1'b0;
        @(posedge clk);
        #1;
        spin_start = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        check("pre-reset state", 32'(spin_state), 2);
        check("pre-reset rpm", 32'(motor_rpm), 1200);
        #3 reset = 1'b0;
        #1;
        check("async reset rpm", 32'(motor_rpm), 0);
        check("async reset state", 32'(spin_state), 0);
        check("async reset active", 32'(spin_active), 0);
        check("async reset done", 32'(spin_done), 0);
        check("async reset aborted", 32'(spin_aborted), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_spin(1200, -1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            t    = $urandom_range(0, 1600);
            mode = $urandom_range(0, 2);
            n    = (t + STEP - 1) / STEP;
            da   = -1;
            if (mode != 0 && t != 0) da = $urandom_range(0, DIV * n + HOLD - 1);
            run_spin(t, da, mode == 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spin_motor_ramp_controller.md
# spin_motor_ramp_controller

Consumes the 11-bit `selected_spin_speed` produced by the spin-speed selector and drives the motor speed command for one spin cycle. On a start request it latches the target RPM, ramps the commanded RPM up in fixed steps, holds at target for a programmed time, then ramps down to zero and reports completion. Sits between the spin-speed selection logic and the motor drive interface, under control of the wash-cycle sequencer.

## Interface
- `STEP_RPM`, 100: RPM added or removed per ramp step.
- `TICK_DIV`, 5: clock cycles per ramp step, ≥1.
- `HOLD_CYCLES`, 300: cycles spent at target speed, ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `spin_start`  in  1  start request; honoured only in IDLE.
- `spin_abort`  in  1  level; forces ramp-down from RAMP_UP or HOLD.
- `door_locked`  in  1  level; low during RAMP_UP or HOLD forces ramp-down, low in IDLE blocks start.
- `selected_spin_speed`  in  11  target RPM, unsigned; sampled only on an accepted start.
- `motor_rpm`  out  11  commanded motor RPM.
- `spin_active`  out  1  high in any state other than IDLE.
- `spin_done`  out  1  one-cycle pulse on return to IDLE after a spin.
- `spin_aborted`  out  1  high from forced ramp-down entry until the next accepted start.
- `spin_state`  out  2  current state encoding.

## Operation
- States: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3.
- Reset (asynchronous, while `reset`=0): state IDLE, `motor_rpm`=0, `spin_active`=0, `spin_done`=0, `spin_aborted`=0, all counters 0, latched target 0.
- IDLE: `spin_start`=1 and `door_locked`=1 accept the start. Latch the target, clear `spin_aborted`, and go to RAMP_UP. A latched target of 0 goes straight to RAMP_DOWN, which completes immediately.
- RAMP_UP: on each step tick, `motor_rpm` = min(`motor_rpm`+`STEP_RPM`, target). Compute the sum at 12 bits so it cannot wrap. When the new value equals the target, go to HOLD in the same edge.
- HOLD: the hold counter counts `HOLD_CYCLES` cycles, then the state goes to RAMP_DOWN.
- RAMP_DOWN: on each step tick, `motor_rpm` = max(`motor_rpm`−`STEP_RPM`, 0), with no underflow. When the result is 0, go to IDLE and pulse `spin_done` for one cycle.
- Forced stop: `spin_abort`=1 or `door_locked`=0 in RAMP_UP or HOLD moves to RAMP_DOWN on the next edge and sets `spin_aborted`. `motor_rpm` is kept as the starting point for the ramp-down.
- In RAMP_DOWN, the abort and door inputs are ignored; ramp-down always completes.
- In non-IDLE states, `spin_start` and `selected_spin_speed` changes are ignored.
- If abort and start arrive in the same cycle while in IDLE, start wins; abort is evaluated from RAMP_UP onward.

## Timing
- The step tick counter clears on every entry to RAMP_UP or RAMP_DOWN. A tick fires when the counter equals `TICK_DIV`−1, and the counter then wraps to 0.
- The first step takes effect `TICK_DIV` edges after the state is entered. The accept edge enters RAMP_UP, so `motor_rpm`=`STEP_RPM` is visible `TICK_DIV` cycles after the start edge.
- The time to reach target is ceil(target/`STEP_RPM`)·`TICK_DIV` cycles after the start edge.
- `spin_done` is registered and is high in the first IDLE cycle only.
- `spin_active` is decoded from the registered state, so it has no extra latency.

## Structure
- Shared package `wm_spin_pkg` holds:
  - the state enum / localparams;
  - `RPM_W`=11;
  - the maximum legal target, `MAX_RPM`=1600.
- Sub-module `spin_step_timer` is a clearable divide-by-`TICK_DIV` tick generator, instantiated once.
- The FSM, RPM arithmetic and hold counter live in the top module.

## Test plan
All scenarios use the defaults except `HOLD_CYCLES`=10.
- Target 1200, start with door locked:
  - `motor_rpm` steps 100, 200, … every 5 cycles and reaches 1200 at cycle 60;
  - it holds for 10 cycles, then falls to 0 in 60 cycles;
  - `spin_done` pulses once and `spin_aborted`=0.
- Target 850: the ramp goes 800→850 on step 9, enters HOLD, and never exceeds 850. Ramp-down goes 850, 750, …, 50, 0.
- Target 1200, `spin_abort` pulsed when `motor_rpm`=400:
  - RAMP_DOWN is entered next edge and `spin_aborted`=1;
  - rpm goes 300, 200, 100, 0 at 5-cycle spacing, then `spin_done`.
- Start with `door_locked`=0 → stays IDLE, `motor_rpm`=0. Door dropped during HOLD → ramp-down from 1200 with `spin_aborted`=1.
- Target 0 → completes within 2 cycles with `motor_rpm` kept at 0 and one `spin_done` pulse. A start with target 500 during RAMP_UP is ignored, and the latched target is unchanged.
- `reset` asserted low mid-HOLD, not aligned to `clk` → `motor_rpm`=0, IDLE and all flags clear immediately. After release, a new start behaves as in the first scenario.
